// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave with a bank of NUM_REGS 32-bit read/write registers.
// The write and read channels run independent FSMs; all outputs are registered.
module axi4_lite_reg_slave #(
  parameter int unsigned NUM_REGS  = 16,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic                     aclk,
  input  logic                     rst_n,
  input  logic [31:0]              awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [31:0]              araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [NUM_REGS*32-1:0]   regs_out
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WS_IDLE, WS_RESP} wstate_t;
  typedef enum logic {RS_IDLE, RS_DATA} rstate_t;

  wstate_t     ws_q, ws_d;
  rstate_t     rs_q, rs_d;
  logic        aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic        awready_q, awready_d, wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] awaddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] regs_q [NUM_REGS];
  logic        commit;

  logic             aw_hs, w_hs, ar_hs;
  logic [31:0]      aw_eff, wd_eff;
  logic [3:0]       ws_eff;
  logic             w_in_range, r_in_range;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic             unused_addr_bits;

  assign aw_hs  = awvalid && awready_q;
  assign w_hs   = wvalid && wready_q;
  assign ar_hs  = arvalid && arready_q;
  // A handshake on the commit edge itself must use the live bus values.
  assign aw_eff = aw_hs ? awaddr : awaddr_q;
  assign wd_eff = w_hs ? wdata : wdata_q;
  assign ws_eff = w_hs ? wstrb : wstrb_q;

  assign w_in_range = (aw_eff[31:IDX_W+2] == '0);
  assign w_idx      = aw_eff[IDX_W+1:2];
  assign r_in_range = (araddr[31:IDX_W+2] == '0);
  assign r_idx      = araddr[IDX_W+1:2];
  assign unused_addr_bits = ^{aw_eff[1:0], araddr[1:0]};

  always_comb begin
    ws_d      = ws_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    unique case (ws_q)
      WS_IDLE: begin
        if (aw_hs) aw_got_d = 1'b1;
        if (w_hs)  w_got_d  = 1'b1;
        if (aw_got_d && w_got_d) begin
          commit    = 1'b1;
          bvalid_d  = 1'b1;
          bresp_d   = w_in_range ? RESP_OKAY : RESP_SLVERR;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          ws_d      = WS_RESP;
        end else begin
          awready_d = !aw_got_d;
          wready_d  = !w_got_d;
        end
      end
      WS_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          ws_d      = WS_IDLE;
        end
      end
    endcase
  end

  // Read path samples regs_q, so a write committing on the same edge is not seen.
  always_comb begin
    rs_d      = rs_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    unique case (rs_q)
      RS_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rdata_d   = r_in_range ? regs_q[r_idx] : 32'h0;
          rresp_d   = r_in_range ? RESP_OKAY : RESP_SLVERR;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          rs_d      = RS_DATA;
        end
      end
      RS_DATA: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          rs_d      = RS_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      ws_q      <= WS_IDLE;
      rs_q      <= RS_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= 32'h0;
    end else begin
      ws_q      <= ws_d;
      rs_q      <= rs_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (aw_hs) awaddr_q <= awaddr;
    if (w_hs) begin
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VAL;
    end else if (commit && w_in_range) begin
      for (int b = 0; b < 4; b++)
        if (ws_eff[b]) regs_q[w_idx][8*b +: 8] <= wd_eff[8*b +: 8];
    end
  end

  always_comb begin
    regs_out = '0;
    for (int k = 0; k < NUM_REGS; k++) regs_out[32*k +: 32] = regs_q[k];
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave (NUM_REGS=16, RESET_VAL=0).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_axi4_lite_reg_slave;

  localparam int NR = 16;

  logic          aclk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]    wstrb = '0;
  logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic          arvalid = 1'b0, rready = 1'b0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [NR*32-1:0] regs_out;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi4_lite_reg_slave #(.NUM_REGS(NR), .RESET_VAL(32'h0)) dut (
    .aclk(aclk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_out(regs_out)
  );

  task automatic chk(input string tag, input logic [NR*32-1:0] obs, input logic [NR*32-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] reg_at(input int k);
    return regs_out[32*k +: 32];
  endfunction

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] exp_resp);
    int  n;
    logic ha, hw;
    n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while ((awvalid || wvalid) && n < 20) begin
      ha = awvalid && awready;
      hw = wvalid && wready;
      tick();
      n++;
      if (ha) awvalid = 1'b0;
      if (hw) wvalid = 1'b0;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk({tag, "_hs_timeout"}, (n < 20), 1);
    chk({tag, "_bvalid"}, bvalid, 1);
    chk({tag, "_bresp"}, bresp, exp_resp);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk({tag, "_bvalid_clr"}, bvalid, 0);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int  n;
    logic ha;
    n = 0;
    araddr = a; arvalid = 1'b1;
    while (arvalid && n < 20) begin
      ha = arvalid && arready;
      tick();
      n++;
      if (ha) arvalid = 1'b0;
    end
    arvalid = 1'b0;
    chk({tag, "_ar_timeout"}, (n < 20), 1);
    chk({tag, "_rvalid"}, rvalid, 1);
    chk({tag, "_rdata"}, rdata, exp_data);
    chk({tag, "_rresp"}, rresp, exp_resp);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk({tag, "_rvalid_clr"}, rvalid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR*32-1:0] snap;

    // Reset held, then released away from the clock edge.
    tick(); tick();
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_awready", awready, 1);
    chk("rel_wready", wready, 1);
    chk("rel_arready", arready, 1);
    chk("rel_bvalid", bvalid, 0);
    chk("rel_rvalid", rvalid, 0);
    chk("rel_regs", regs_out, '0);

    // Full word write and read back.
    do_write("w08", 32'h08, 32'hA5A5_1234, 4'hF, 2'b00);
    chk("w08_reg2", reg_at(2), 32'hA5A5_1234);
    do_read("r08", 32'h08, 32'hA5A5_1234, 2'b00);

    // Partial strobes over a cleared register.
    do_write("clr08", 32'h08, 32'h0, 4'hF, 2'b00);
    do_write("part08", 32'h08, 32'hFFFF_FFFF, 4'b0101, 2'b00);
    do_read("rpart08", 32'h08, 32'h00FF_00FF, 2'b00);

    // Zero strobe: OKAY, nothing written.
    do_write("nostrb", 32'h08, 32'h1234_5678, 4'h0, 2'b00);
    chk("nostrb_reg2", reg_at(2), 32'h00FF_00FF);

    // W three cycles ahead of AW.
    wdata = 32'h1111_2222; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("wfirst_wready", wready, 0);
    chk("wfirst_awready", awready, 1);
    tick(); tick();
    chk("wfirst_bvalid", bvalid, 0);
    chk("wfirst_reg3_pre", reg_at(3), 32'h0);
    awaddr = 32'h0C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("wfirst_bvalid_set", bvalid, 1);
    chk("wfirst_bresp", bresp, 2'b00);
    chk("wfirst_reg3", reg_at(3), 32'h1111_2222);
    bready = 1'b1; tick(); bready = 1'b0;
    chk("wfirst_bvalid_clr", bvalid, 0);

    // Out-of-range accesses.
    snap = regs_out;
    do_write("oor40", 32'h40, 32'hDEAD_BEEF, 4'hF, 2'b10);
    chk("oor40_regs", regs_out, snap);
    do_write("oorhi", 32'h8000_0008, 32'hDEAD_BEEF, 4'hF, 2'b10);
    chk("oorhi_regs", regs_out, snap);
    do_read("roor40", 32'h40, 32'h0, 2'b10);
    do_read("rlast", 32'h3F, 32'h0, 2'b00);

    // Write response backpressure.
    awaddr = 32'h10; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bp_bvalid0", bvalid, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_bvalid_hold", bvalid, 1);
      chk("bp_awready_low", awready, 0);
    end
    bready = 1'b1; tick(); bready = 1'b0;
    chk("bp_bvalid_clr", bvalid, 0);
    chk("bp_awready_back", awready, 1);

    // Read backpressure, with a write to the same register during the hold.
    araddr = 32'h10; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("rbp_rvalid0", rvalid, 1);
    chk("rbp_rdata0", rdata, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rbp_rvalid_hold", rvalid, 1);
      chk("rbp_arready_low", arready, 0);
    end
    do_write("rbp_w10", 32'h10, 32'h0BAD_0BAD, 4'hF, 2'b00);
    chk("rbp_rdata_stable", rdata, 32'hCAFE_F00D);
    chk("rbp_reg4", reg_at(4), 32'h0BAD_0BAD);
    rready = 1'b1; tick(); rready = 1'b0;
    chk("rbp_rvalid_clr", rvalid, 0);

    // Read and write to the same register committing on the same edge.
    awaddr = 32'h14; wdata = 32'h1234_5678; wstrb = 4'hF;
    araddr = 32'h14; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same_bvalid", bvalid, 1);
    chk("same_rvalid", rvalid, 1);
    chk("same_rdata_old", rdata, 32'h0);
    chk("same_reg5", reg_at(5), 32'h1234_5678);
    bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;
    chk("same_clr", {bvalid, rvalid}, 2'b00);

    // Reset during a write that has captured only W.
    wdata = 32'hDEAD_0000; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_regs", regs_out, '0);
    chk("mid_rst_ready", {awready, wready, arready}, 3'b000);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rel_ready", {awready, wready, arready}, 3'b111);
    awaddr = 32'h18; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("mid_no_stale_bvalid", bvalid, 0);
    chk("mid_reg6", reg_at(6), 32'h0);
    chk("mid_wready", wready, 1);
    wdata = 32'h0000_0005; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("mid_commit_bvalid", bvalid, 1);
    chk("mid_commit_reg6", reg_at(6), 32'h5);
    bready = 1'b1; tick(); bready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
